// File: rtl/ckpt_pkg.sv
// Shared types and helpers for the branch checkpoint controller.
// AL_SIZE comes from the core-wide header; it defaults to 32 when that header has not been included.
`ifndef AL_SIZE
`define AL_SIZE 32
`endif

package ckpt_pkg;

  localparam int CKPT_DEPTH   = 8;
  localparam int CKPT_AL_SIZE = `AL_SIZE;
  localparam int CKPT_AL_W    = $clog2(CKPT_AL_SIZE);
  localparam int CKPT_ID_W    = $clog2(CKPT_DEPTH);

  typedef enum logic [1:0] {IDLE, RECOVER, SETTLE} ckpt_state_e;

  typedef logic [CKPT_ID_W-1:0] ckpt_id_t;
  typedef logic [CKPT_AL_W-1:0] al_idx_t;

  // Strictly between lo and hi walking forward round the ring; lo==hi means the whole ring except lo.
  function automatic logic al_in_range(input al_idx_t x, input al_idx_t lo, input al_idx_t hi);
    if (lo < hi)
      return (x > lo) && (x < hi);
    else if (lo > hi)
      return (x > lo) || (x < hi);
    else
      return x != lo;
  endfunction

  function automatic al_idx_t al_inc(input al_idx_t x);
    if (x == al_idx_t'(CKPT_AL_SIZE - 1))
      return '0;
    else
      return x + al_idx_t'(1);
  endfunction

endpackage

// File: rtl/ckpt_free_alloc.sv
// Lowest-index free checkpoint slot finder and full flag.
module ckpt_free_alloc
  import ckpt_pkg::*;
#(
  parameter int DEPTH = CKPT_DEPTH,
  parameter int ID_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  output logic [ID_W-1:0]  free_id,
  output logic             full
);

  always_comb begin
    free_id = '0;
    full    = &valid;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i])
        free_id = ID_W'(i);
    end
  end

endmodule

// File: rtl/checkpoint_controller.sv
// Branch checkpoint allocator with mispredict recovery and wrap-aware younger-checkpoint flush.
// Optional CKPT_PERF_CNT_EN adds saturating mispredict and alloc-stall counters.
module checkpoint_controller
  import ckpt_pkg::*;
#(
  parameter int DEPTH = CKPT_DEPTH,
  parameter int AL_W  = CKPT_AL_W,
  parameter int ID_W  = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_req,
  input  logic [AL_W-1:0]  alloc_al_idx,
  output logic             alloc_ready,
  output logic [ID_W-1:0]  alloc_id,
  input  logic             resolve_valid,
  input  logic [ID_W-1:0]  resolve_id,
  input  logic             resolve_mispred,
  output logic             resolve_ready,
  input  logic [AL_W-1:0]  al_front,
  output logic             recover_valid,
  output logic [AL_W-1:0]  recover_front,
  output logic [DEPTH-1:0] flush_mask,
  output logic [DEPTH-1:0] ckpt_valid
`ifdef CKPT_PERF_CNT_EN
  ,
  output logic [31:0]      perf_mispred_cnt,
  output logic [31:0]      perf_alloc_stall_cnt
`endif
);

  ckpt_state_e      state, state_nxt;
  logic [ID_W-1:0]  free_id;
  logic             full;
  logic             id_live;
  logic             alloc_fire;
  logic             res_clr;
  logic             mis_fire;
  logic [DEPTH-1:0] set_mask;
  logic [DEPTH-1:0] clr_mask;

  logic [AL_W-1:0]  al_list [DEPTH];
  logic [AL_W-1:0]  br_idx_p1;
  logic [AL_W-1:0]  old_front_p1;
  logic [ID_W-1:0]  mis_id_p1;

  ckpt_free_alloc #(
    .DEPTH (DEPTH),
    .ID_W  (ID_W)
  ) u_free_alloc (
    .valid   (ckpt_valid),
    .free_id (free_id),
    .full    (full)
  );

  always_comb begin
    id_live       = ckpt_valid[resolve_id];
    alloc_ready   = (state == IDLE) && !full && !(resolve_valid && resolve_mispred);
    alloc_id      = free_id;
    alloc_fire    = alloc_req && alloc_ready;
    resolve_ready = resolve_valid && (!resolve_mispred || (state == IDLE));
    res_clr       = resolve_valid && !resolve_mispred && id_live;
    mis_fire      = resolve_valid && resolve_mispred && (state == IDLE) && id_live;
    set_mask      = alloc_fire ? (DEPTH'(1) << free_id) : '0;
    clr_mask      = res_clr ? (DEPTH'(1) << resolve_id) : '0;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (mis_fire) state_nxt = RECOVER;
      RECOVER: state_nxt = SETTLE;
      SETTLE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: recovery outputs derived from the context latched at the mispredict
  always_comb begin
    recover_valid = (state == RECOVER);
    recover_front = '0;
    flush_mask    = '0;
    if (state == RECOVER) begin
      recover_front = al_inc(br_idx_p1);
      for (int i = 0; i < DEPTH; i++) begin
        flush_mask[i] = ckpt_valid[i] &&
                        ((ID_W'(i) == mis_id_p1) || al_in_range(al_list[i], br_idx_p1, old_front_p1));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      ckpt_valid <= '0;
    end else begin
      state      <= state_nxt;
      ckpt_valid <= (ckpt_valid | set_mask) & ~clr_mask & ~flush_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (alloc_fire)
      al_list[free_id] <= alloc_al_idx;
    if (mis_fire) begin
      br_idx_p1    <= al_list[resolve_id];
      old_front_p1 <= al_front;
      mis_id_p1    <= resolve_id;
    end
  end

`ifdef CKPT_PERF_CNT_EN
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_mispred_cnt     <= '0;
      perf_alloc_stall_cnt <= '0;
    end else begin
      if (mis_fire)
        perf_mispred_cnt <= sat_inc(perf_mispred_cnt);
      if (alloc_req && !alloc_ready)
        perf_alloc_stall_cnt <= sat_inc(perf_alloc_stall_cnt);
    end
  end
`endif

endmodule
